// File: rtl/sram_resp.sv
// sram_resp: responder end of the 36-bit bus packet interface for the data-RAM
// window. Each packet {rw, wdata, addr} is turned into one timed access on an
// external asynchronous 16-bit SRAM. ACCESS_CYCLES sets how long the strobes are
// held, so slower SRAM parts can be fitted.
module sram_resp #(
    parameter int ACCESS_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic        sck,
    input  logic        rst,
    input  logic        cs_n,
    input  logic [35:0] mosi,
    output logic [15:0] miso,
    output logic        ready,
    output logic [18:0] sram_addr,
    inout  wire  [15:0] sram_data,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub,
    output logic        sram_lb
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rw_q;
    logic [15:0]      wdata_q;
    logic             drv_en;

    // The data bus is driven only from registers. The enable is raised solely
    // for writes, and oe_n is low solely for reads, so the two never overlap.
    assign sram_data = drv_en ? wdata_q : 16'hzzzz;

    // Access sequencer. Every SRAM strobe and every bus-facing output is a register.
    always_ff @(posedge sck) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            drv_en    <= 1'b0;
            miso      <= '0;
            ready     <= 1'b0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub   <= 1'b1;
            sram_lb   <= 1'b1;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    drv_en    <= 1'b0;
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_we_n <= 1'b1;
                    sram_ub   <= 1'b1;
                    sram_lb   <= 1'b1;
                    if (!cs_n) begin
                        // The packet is latched here. Later changes to cs_n or
                        // mosi are not looked at until the bus returns to IDLE.
                        rw_q      <= mosi[35];
                        wdata_q   <= mosi[34:19];
                        sram_addr <= mosi[18:0];
                        cnt       <= CNT_W'(ACCESS_CYCLES - 1);
                        sram_ce_n <= 1'b0;
                        sram_ub   <= 1'b0;
                        sram_lb   <= 1'b0;
                        sram_oe_n <= mosi[35];
                        sram_we_n <= ~mosi[35];
                        drv_en    <= mosi[35];
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        // oe_n is still low at this edge, so the read data is valid.
                        if (!rw_q) miso <= sram_data;
                        ready     <= 1'b1;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        sram_ub   <= 1'b1;
                        sram_lb   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Write data stays on the bus through this cycle. This
                    // gives hold time after the rising edge of we_n.
                    drv_en <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_resp.sv
// Directed bench for sram_resp with ACCESS_CYCLES = 2. It contains a behavioural
// asynchronous SRAM and a known "probe" driver. The probe is used to detect
// whether the DUT releases the data bus.
module tb_sram_resp;

    localparam logic [15:0] PROBE = 16'hA5C3;

    logic        sck = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic [35:0] mosi = '0;
    logic [15:0] miso;
    logic        ready;
    logic [18:0] sram_addr;
    wire  [15:0] sram_data;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub, sram_lb;
    logic [5:0]  strb;

    int n_chk = 0;
    int n_fail = 0;

    // SRAM model state
    logic [15:0] mem [logic [18:0]];
    logic        mdrv = 1'b0;
    logic [15:0] mrd = '0;
    logic        probe = 1'b1;

    always #5 sck = ~sck;

    sram_resp #(.ACCESS_CYCLES(2), .CNT_W(4)) dut (
        .sck(sck), .rst(rst), .cs_n(cs_n), .mosi(mosi), .miso(miso), .ready(ready),
        .sram_addr(sram_addr), .sram_data(sram_data), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub(sram_ub), .sram_lb(sram_lb)
    );

    assign sram_data = mdrv ? mrd : (probe ? PROBE : 16'hzzzz);
    assign strb = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub, sram_lb, ready};

    // Asynchronous SRAM, evaluated mid-cycle. Unwritten words read back as addr ^ 5A5A.
    always @(negedge sck) begin
        if (!sram_ce_n && !sram_we_n) mem[sram_addr] = sram_data;
        mdrv = !sram_ce_n && !sram_oe_n && sram_we_n;
        mrd  = mem.exists(sram_addr) ? mem[sram_addr] : (sram_addr[15:0] ^ 16'h5A5A);
    end

    task automatic tick;
        @(posedge sck);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; cs_n = 1'b0; mosi = {1'b1, 16'hBEEF, 19'h00012}; probe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_chk++; if (strb !== 6'b111110) begin n_fail++; $display("FAIL reset_strobes: got %b want 111110", strb); end
            n_chk++; if (miso !== 16'h0) begin n_fail++; $display("FAIL reset_miso: got %h want 0000", miso); end
            n_chk++; if (sram_data !== PROBE) begin n_fail++; $display("FAIL reset_bus_released: got %h want %h", sram_data, PROBE); end
            n_chk++; if (sram_addr !== 19'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
        end
        cs_n = 1'b1;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_write;
        int we_cnt = 0;
        int rdy_cnt = 0;
        probe = 1'b0;
        cs_n = 1'b0; mosi = {1'b1, 16'hBEEF, 19'h00012};
        tick;
        cs_n = 1'b1; mosi = '0;
        for (int t = 1; t <= 6; t++) begin
            if (!sram_we_n) we_cnt++;
            if (ready) begin
                rdy_cnt++;
                n_chk++; if (t != 3) begin n_fail++; $display("FAIL write_ready_cycle: got %0d want 3", t); end
            end
            if (t <= 2) begin
                n_chk++; if (strb !== 6'b010000) begin n_fail++; $display("FAIL write_access_strobes: cyc %0d got %b want 010000", t, strb); end
                n_chk++; if (sram_addr !== 19'h00012) begin n_fail++; $display("FAIL write_addr: got %h want 00012", sram_addr); end
                n_chk++; if (sram_data !== 16'hBEEF) begin n_fail++; $display("FAIL write_data: got %h want beef", sram_data); end
            end
            if (t == 3) begin
                n_chk++; if (strb !== 6'b111111) begin n_fail++; $display("FAIL write_done_strobes: got %b want 111111", strb); end
                n_chk++; if (sram_data !== 16'hBEEF) begin n_fail++; $display("FAIL write_data_hold: got %h want beef", sram_data); end
            end
            if (t == 4) begin
                probe = 1'b1; #1;
                n_chk++; if (sram_data !== PROBE) begin n_fail++; $display("FAIL write_bus_release: got %h want %h", sram_data, PROBE); end
            end
            tick;
        end
        n_chk++; if (we_cnt != 2) begin n_fail++; $display("FAIL write_we_width: got %0d want 2", we_cnt); end
        n_chk++; if (rdy_cnt != 1) begin n_fail++; $display("FAIL write_ready_count: got %0d want 1", rdy_cnt); end
        n_chk++; if (miso !== 16'h0) begin n_fail++; $display("FAIL write_miso_unchanged: got %h want 0000", miso); end
        n_chk++; if (!mem.exists(19'h00012) || mem[19'h00012] !== 16'hBEEF) begin n_fail++; $display("FAIL write_sram_content: want beef at 00012"); end
    endtask

    task automatic test_read;
        probe = 1'b1;
        cs_n = 1'b0; mosi = {1'b0, 16'h0000, 19'h00012};
        tick;
        cs_n = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            if (t <= 2) begin
                n_chk++; if (strb !== 6'b001000) begin n_fail++; $display("FAIL read_access_strobes: cyc %0d got %b want 001000", t, strb); end
                n_chk++; if (sram_addr !== 19'h00012) begin n_fail++; $display("FAIL read_addr: got %h want 00012", sram_addr); end
            end
            if (t == 1) begin
                n_chk++; if (sram_data !== PROBE) begin n_fail++; $display("FAIL read_bus_undriven: got %h want %h", sram_data, PROBE); end
            end
            if (t == 3) begin
                n_chk++; if (strb !== 6'b111111) begin n_fail++; $display("FAIL read_done_strobes: got %b want 111111", strb); end
            end
            if (t >= 3) begin
                n_chk++; if (miso !== 16'hBEEF) begin n_fail++; $display("FAIL read_miso: cyc %0d got %h want beef", t, miso); end
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        int first = 0;
        int second = 0;
        probe = 1'b0;
        cs_n = 1'b0; mosi = {1'b1, 16'h1234, 19'h7FFFF};
        tick;
        for (int t = 1; t <= 12; t++) begin
            if (ready) begin
                if (first == 0) begin
                    first = t;
                    mosi = {1'b0, 16'h0000, 19'h7FFFF};
                end else if (second == 0) begin
                    second = t;
                    cs_n = 1'b1;
                    n_chk++; if (miso !== 16'h1234) begin n_fail++; $display("FAIL b2b_miso: got %h want 1234", miso); end
                end
            end
            tick;
        end
        probe = 1'b1;
        n_chk++; if (first != 3) begin n_fail++; $display("FAIL b2b_first_ready: got %0d want 3", first); end
        n_chk++; if (second != 7) begin n_fail++; $display("FAIL b2b_second_ready: got %0d want 7", second); end
    endtask

    task automatic test_ignored_change;
        probe = 1'b1;
        cs_n = 1'b0; mosi = {1'b0, 16'h0000, 19'h00010};
        tick;
        mosi = {1'b0, 16'h0000, 19'h00001};
        for (int t = 1; t <= 3; t++) begin
            n_chk++; if (sram_addr !== 19'h00010) begin n_fail++; $display("FAIL ignored_addr: cyc %0d got %h want 00010", t, sram_addr); end
            if (t == 3) begin
                n_chk++; if (ready !== 1'b1 || miso !== 16'h5A4A) begin n_fail++; $display("FAIL ignored_read: ready %b miso %h want 1 5a4a", ready, miso); end
                cs_n = 1'b1;
            end
            tick;
        end
        tick;
    endtask

    task automatic test_abort;
        int rdy_cnt = 0;
        int rdy_t = 0;
        probe = 1'b0;
        cs_n = 1'b0; mosi = {1'b1, 16'hCAFE, 19'h00020};
        tick;
        n_chk++; if (strb !== 6'b010000) begin n_fail++; $display("FAIL abort_write_started: got %b want 010000", strb); end
        rst = 1'b1; cs_n = 1'b1;
        tick;
        probe = 1'b1; #1;
        n_chk++; if (strb !== 6'b111110) begin n_fail++; $display("FAIL abort_strobes: got %b want 111110", strb); end
        n_chk++; if (sram_data !== PROBE) begin n_fail++; $display("FAIL abort_bus_release: got %h want %h", sram_data, PROBE); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (ready) rdy_cnt++;
        end
        n_chk++; if (rdy_cnt != 0) begin n_fail++; $display("FAIL abort_no_ready: got %0d pulses want 0", rdy_cnt); end
        n_chk++; if (miso !== 16'h0) begin n_fail++; $display("FAIL abort_miso_reset: got %h want 0000", miso); end
        cs_n = 1'b0; mosi = {1'b0, 16'h0000, 19'h00012};
        tick;
        cs_n = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            if (ready && rdy_t == 0) begin
                rdy_t = t;
                n_chk++; if (miso !== 16'hBEEF) begin n_fail++; $display("FAIL abort_recover_miso: got %h want beef", miso); end
            end
            tick;
        end
        n_chk++; if (rdy_t != 3) begin n_fail++; $display("FAIL abort_recover_ready: got %0d want 3", rdy_t); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_ignored_change;
        test_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
